// File: rtl/count_ctrl.sv
// Control stage for the up-counter: prescaled enable, terminal-count handling
// (one-shot or periodic wrap) and a valid/ready preset-load port.
module count_ctrl #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned PWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PWIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0]  cfg_limit,
  input  logic              cfg_oneshot,
  input  logic              start,
  input  logic              stop,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [WIDTH-1:0]  ld_data,
  input  logic [WIDTH-1:0]  cnt_val,
  output logic              cen,
  output logic              wen,
  output logic [WIDTH-1:0]  dat,
  output logic              busy,
  output logic              done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]        state, state_n;
  logic [PWIDTH-1:0] pcnt, pcnt_n;
  logic              ld_pend, ld_pend_n;
  logic [WIDTH-1:0]  ld_q, ld_q_n;
  logic              done_n;
  logic              tick, term;

  // State, prescaler, load buffer and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pcnt    <= '0;
      ld_pend <= 1'b0;
      ld_q    <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      pcnt    <= pcnt_n;
      ld_pend <= ld_pend_n;
      ld_q    <= ld_q_n;
      done    <= done_n;
    end
  end

  // Next state and counter-control outputs; a pending load pre-empts tick/term
  always_comb begin
    state_n   = state;
    pcnt_n    = pcnt;
    ld_pend_n = ld_pend;
    ld_q_n    = ld_q;
    done_n    = 1'b0;
    cen       = 1'b0;
    wen       = 1'b0;
    dat       = '0;
    ld_ready  = !ld_pend;
    busy      = (state == RUN);
    tick      = (state == RUN) && (pcnt == cfg_div);
    term      = tick && (cnt_val == cfg_limit);

    if (state == RUN) begin
      pcnt_n = tick ? '0 : pcnt + PWIDTH'(1);
    end

    if (ld_pend) begin
      wen       = 1'b1;
      dat       = ld_q;
      pcnt_n    = '0;
      ld_pend_n = 1'b0;
    end else if (term) begin
      done_n = 1'b1;
      if (cfg_oneshot) begin
        state_n = IDLE;
      end else begin
        wen = 1'b1;
      end
    end else if (tick) begin
      cen = 1'b1;
    end

    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_n = RUN;
          pcnt_n  = '0;
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Prescaler rests at zero whenever the next state is idle
    if (state_n == IDLE) begin
      pcnt_n = '0;
    end

    if (ld_valid && !ld_pend) begin
      ld_q_n    = ld_data;
      ld_pend_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_count_ctrl.sv
// Bench for count_ctrl: drives stimulus per cycle against a behavioural up-counter
// and checks outputs through an expected-value queue.
module tb_count_ctrl;

  typedef struct packed {
    logic       cen;
    logic       wen;
    logic [7:0] dat;
    logic       rdy;
    logic       busy;
    logic       done;
    logic [7:0] cnt;
  } exp_t;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       ldv;
    logic [7:0] ldd;
    exp_t       e;
  } vec_t;

  typedef struct {
    exp_t  e;
    string name;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cfg_div;
  logic [7:0] cfg_limit;
  logic       cfg_oneshot;
  logic       start, stop, ld_valid, ld_ready;
  logic [7:0] ld_data, cnt_val, dat;
  logic       cen, wen, busy, done;

  int checks = 0;
  int errors = 0;
  sb_t sb[$];
  sb_t item;
  vec_t tbl[11];

  count_ctrl #(.WIDTH(8), .PWIDTH(8)) dut (
    .clk(clk), .rst(rst), .cfg_div(cfg_div), .cfg_limit(cfg_limit),
    .cfg_oneshot(cfg_oneshot), .start(start), .stop(stop),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .cnt_val(cnt_val), .cen(cen), .wen(wen), .dat(dat), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural model of the downstream up-counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_val <= 8'h00;
    else if (wen) cnt_val <= dat;
    else if (cen) cnt_val <= cnt_val + 8'd1;
  end

  function automatic exp_t mk(input logic c, input logic w, input logic [7:0] d,
                              input logic r, input logic b, input logic dn,
                              input logic [7:0] n);
    exp_t e;
    e.cen = c; e.wen = w; e.dat = d; e.rdy = r; e.busy = b; e.done = dn; e.cnt = n;
    return e;
  endfunction

  function automatic vec_t v(input logic st, input logic sp, input logic lv,
                             input logic [7:0] ld, input exp_t e);
    vec_t r;
    r.start = st; r.stop = sp; r.ldv = lv; r.ldd = ld; r.e = e;
    return r;
  endfunction

  function automatic string fmt(input exp_t e);
    return $sformatf("cen=%0b wen=%0b dat=%h rdy=%0b busy=%0b done=%0b cnt=%h",
                     e.cen, e.wen, e.dat, e.rdy, e.busy, e.done, e.cnt);
  endfunction

  function automatic exp_t cur();
    return mk(cen, wen, dat, ld_ready, busy, done, cnt_val);
  endfunction

  task automatic chk(input string name, input exp_t got, input exp_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %s want %s", name, fmt(got), fmt(want));
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected in this cycle
  task automatic step(input logic st, input logic sp, input logic lv,
                      input logic [7:0] ld, input exp_t e, input string name);
    sb_t s;
    start = st; stop = sp; ld_valid = lv; ld_data = ld;
    s.e = e; s.name = name;
    sb.push_back(s);
    @(posedge clk);
    #1;
  endtask

  // Compare mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      item = sb.pop_front();
      chk(item.name, cur(), item.e);
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
    cfg_div = 8'd3; cfg_limit = 8'd5; cfg_oneshot = 1'b1;
    #2;
    chk("reset", cur(), mk(0, 0, 8'h00, 1, 0, 0, 8'h00));
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // One-shot, div=3, limit=5: 24 clocks from start
    step(1, 0, 0, 8'h00, mk(0, 0, 8'h00, 1, 0, 0, 8'h00), "t1_start");
    for (int k = 0; k < 24; k++)
      step(0, 0, 0, 8'h00, mk((k % 4 == 3) && (k < 20), 0, 8'h00, 1, 1, 0, 8'(k / 4)), "t1_run");
    step(0, 0, 0, 8'h00, mk(0, 0, 8'h00, 1, 0, 1, 8'h05), "t1_done");
    step(0, 0, 0, 8'h00, mk(0, 0, 8'h00, 1, 0, 0, 8'h05), "t1_after");

    // Periodic, div=0, limit=2
    step(0, 0, 1, 8'h00, mk(0, 0, 8'h00, 1, 0, 0, 8'h05), "t2_ld");
    step(0, 0, 0, 8'h00, mk(0, 1, 8'h00, 0, 0, 0, 8'h05), "t2_wen");
    cfg_div = 8'd0; cfg_limit = 8'd2; cfg_oneshot = 1'b0;
    step(1, 0, 0, 8'h00, mk(0, 0, 8'h00, 1, 0, 0, 8'h00), "t2_start");
    for (int k = 0; k < 9; k++)
      step(0, k == 8, 0, 8'h00,
           mk(k % 3 != 2, k % 3 == 2, 8'h00, 1, 1, (k > 0) && (k % 3 == 0), 8'(k % 3)), "t2_run");
    step(0, 0, 0, 8'h00, mk(0, 0, 8'h00, 1, 0, 1, 8'h00), "t2_stop");
    step(0, 0, 0, 8'h00, mk(0, 0, 8'h00, 1, 0, 0, 8'h00), "t2_idle");

    // Load 0x3C while running, div=1
    cfg_div = 8'd1; cfg_limit = 8'hFF;
    step(1, 0, 0, 8'h00, mk(0, 0, 8'h00, 1, 0, 0, 8'h00), "t3_start");
    step(0, 0, 0, 8'h00, mk(0, 0, 8'h00, 1, 1, 0, 8'h00), "t3_k0");
    step(0, 0, 0, 8'h00, mk(1, 0, 8'h00, 1, 1, 0, 8'h00), "t3_k1");
    step(0, 0, 1, 8'h3C, mk(0, 0, 8'h00, 1, 1, 0, 8'h01), "t3_ld");
    step(0, 0, 0, 8'h00, mk(0, 1, 8'h3C, 0, 1, 0, 8'h01), "t3_wen");
    step(0, 0, 0, 8'h00, mk(0, 0, 8'h00, 1, 1, 0, 8'h3C), "t3_restart");
    step(0, 0, 0, 8'h00, mk(1, 0, 8'h00, 1, 1, 0, 8'h3C), "t3_cen");
    step(0, 1, 0, 8'h00, mk(0, 0, 8'h00, 1, 1, 0, 8'h3D), "t3_stop");
    step(0, 0, 0, 8'h00, mk(0, 0, 8'h00, 1, 0, 0, 8'h3D), "t3_idle");

    // Back-to-back loads, then a load landing on a periodic terminal cycle
    cfg_div = 8'd0; cfg_limit = 8'd4; cfg_oneshot = 1'b0;
    tbl[0]  = v(0, 0, 1, 8'hAA, mk(0, 0, 8'h00, 1, 0, 0, 8'h3D));
    tbl[1]  = v(0, 0, 1, 8'hBB, mk(0, 1, 8'hAA, 0, 0, 0, 8'h3D));
    tbl[2]  = v(0, 0, 1, 8'hCC, mk(0, 0, 8'h00, 1, 0, 0, 8'hAA));
    tbl[3]  = v(0, 0, 1, 8'hDD, mk(0, 1, 8'hCC, 0, 0, 0, 8'hAA));
    tbl[4]  = v(0, 0, 1, 8'h04, mk(0, 0, 8'h00, 1, 0, 0, 8'hCC));
    tbl[5]  = v(0, 0, 0, 8'h00, mk(0, 1, 8'h04, 0, 0, 0, 8'hCC));
    tbl[6]  = v(1, 0, 1, 8'h11, mk(0, 0, 8'h00, 1, 0, 0, 8'h04));
    tbl[7]  = v(0, 0, 0, 8'h00, mk(0, 1, 8'h11, 0, 1, 0, 8'h04));
    tbl[8]  = v(0, 0, 0, 8'h00, mk(1, 0, 8'h00, 1, 1, 0, 8'h11));
    tbl[9]  = v(0, 1, 0, 8'h00, mk(1, 0, 8'h00, 1, 1, 0, 8'h12));
    tbl[10] = v(0, 0, 0, 8'h00, mk(0, 0, 8'h00, 1, 0, 0, 8'h13));
    for (int i = 0; i < 11; i++)
      step(tbl[i].start, tbl[i].stop, tbl[i].ldv, tbl[i].ldd, tbl[i].e, $sformatf("tbl%0d", i));

    // start+stop together from idle, then stop mid-count at 3
    cfg_limit = 8'hFF;
    step(1, 1, 0, 8'h00, mk(0, 0, 8'h00, 1, 0, 0, 8'h13), "t5_both");
    step(0, 0, 0, 8'h00, mk(0, 0, 8'h00, 1, 0, 0, 8'h13), "t5_idle0");
    step(0, 0, 1, 8'h00, mk(0, 0, 8'h00, 1, 0, 0, 8'h13), "t5_idle1");
    step(0, 0, 0, 8'h00, mk(0, 1, 8'h00, 0, 0, 0, 8'h13), "t5_wen");
    step(1, 0, 0, 8'h00, mk(0, 0, 8'h00, 1, 0, 0, 8'h00), "t5_start");
    step(0, 0, 0, 8'h00, mk(1, 0, 8'h00, 1, 1, 0, 8'h00), "t5_k0");
    step(1, 0, 0, 8'h00, mk(1, 0, 8'h00, 1, 1, 0, 8'h01), "t5_k1");
    step(0, 1, 0, 8'h00, mk(1, 0, 8'h00, 1, 1, 0, 8'h02), "t5_k2");
    step(0, 0, 0, 8'h00, mk(0, 0, 8'h00, 1, 0, 0, 8'h03), "t5_hold0");
    step(0, 0, 0, 8'h00, mk(0, 0, 8'h00, 1, 0, 0, 8'h03), "t5_hold1");

    // Asynchronous reset while a load is pending
    cfg_div = 8'd2;
    step(1, 0, 0, 8'h00, mk(0, 0, 8'h00, 1, 0, 0, 8'h03), "t6_start");
    step(0, 0, 1, 8'h55, mk(0, 0, 8'h00, 1, 1, 0, 8'h03), "t6_ld");
    ld_valid = 1'b0;
    chk("t6_pend", cur(), mk(0, 1, 8'h55, 0, 1, 0, 8'h03));
    #2 rst = 1'b1;
    #1 chk("t6_rst", cur(), mk(0, 0, 8'h00, 1, 0, 0, 8'h00));
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      step(0, 0, 0, 8'h00, mk(0, 0, 8'h00, 1, 0, 0, 8'h00), "t6_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
